// File: rtl/ldpc_pkg.sv
// Shared parameters and helpers for the QC-LDPC input front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ldpc_pkg;

    // Production codeword geometry.
    localparam int CW_BITS_DEF = 9216;
    localparam int DIN_W_DEF   = 8;

    // Beats needed to fill one codeword bank.
    function automatic int calc_beats(input int cw_bits, input int din_w);
        return cw_bits / din_w;
    endfunction

    // Beat counter width; clamped to 1 so a single-beat frame still gets a legal vector.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // A codeword must be an integral number of beats.
    function automatic bit cw_div_ok(input int cw_bits, input int din_w);
        return (din_w > 0) && (cw_bits >= din_w) && ((cw_bits % din_w) == 0);
    endfunction

endpackage

// File: rtl/ldpc_cw_bank.sv
// One codeword bank: shift-in data register plus a full flag.
// Latency: a shifted beat is visible on data one cycle after shift_en.
// Backpressure: none internally; the caller must not shift while full is set.
//
// Ports: clk, rst_n; shift_en/d_in shift one beat into the LSBs;
//        set_full/clr_full drive the full flag; data/full are registered.
module ldpc_cw_bank
    import ldpc_pkg::*;
#(
    parameter int CW_BITS = CW_BITS_DEF,
    parameter int DIN_W   = DIN_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic [DIN_W-1:0]   d_in,
    input  logic               set_full,
    input  logic               clr_full,
    output logic [CW_BITS-1:0] data,
    output logic               full
);

    logic [CW_BITS-1:0] data_nxt;

    // Older beats move towards the MSBs, so the first beat of a frame ends on top.
    generate
        if (CW_BITS > DIN_W) begin : g_shift
            assign data_nxt = {data[CW_BITS-DIN_W-1:0], d_in};
        end else begin : g_single
            assign data_nxt = d_in;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (shift_en) begin
                data <= data_nxt;
            end
            // Set and clear never target the same bank in one cycle; set wins defensively.
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ldpc_cw_loader.sv
// Ping-pong deserialiser from DIN_W-bit beats into CW_BITS-bit codewords for the decoder.
// Latency: the last beat of a frame accepted at edge k raises frame_valid from edge k.
// Backpressure: in_rdy drops while the write bank is full; beats offered then are dropped and flag ovf_err.
//
// Ports: clk, rst_n; en_din/d_in beat stream, abort discards the partial frame;
//        in_rdy ready; frame_valid/frame_data/frame_take frame handoff;
//        ovf_err sticky overflow with err_clr; beat_cnt beats in the current write bank.
module ldpc_cw_loader
    import ldpc_pkg::*;
#(
    parameter  int CW_BITS = CW_BITS_DEF,
    parameter  int DIN_W   = DIN_W_DEF,
    localparam int BEATS   = calc_beats(CW_BITS, DIN_W),
    localparam int CNT_W   = calc_cnt_w(BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_din,
    input  logic [DIN_W-1:0]   d_in,
    input  logic               abort,
    output logic               in_rdy,
    output logic               frame_valid,
    output logic [CW_BITS-1:0] frame_data,
    input  logic               frame_take,
    output logic               ovf_err,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   beat_cnt
);

    generate
        if (!cw_div_ok(CW_BITS, DIN_W)) begin : g_bad_geometry
            $error("ldpc_cw_loader: CW_BITS must be a non-zero multiple of DIN_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic               wr_sel;
    logic               rd_sel;
    logic [1:0]         bank_full;
    logic [CW_BITS-1:0] bank_data [2];
    logic               accept;
    logic               last_beat;
    logic               take;
    logic [1:0]         shift_en;
    logic [1:0]         set_full;
    logic [1:0]         clr_full;

    // All outputs below are selected from registered state only.
    assign in_rdy      = !bank_full[wr_sel];
    assign frame_valid = bank_full[rd_sel];
    assign frame_data  = bank_data[rd_sel];

    // Abort beats a coincident beat: it is neither written nor counted as overflow.
    assign accept    = en_din && in_rdy && !abort;
    assign last_beat = accept && (beat_cnt == LAST_CNT);
    assign take      = frame_take && frame_valid;

    always_comb begin
        shift_en = '0;
        set_full = '0;
        clr_full = '0;
        shift_en[wr_sel] = accept;
        set_full[wr_sel] = last_beat;
        clr_full[rd_sel] = take;
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_bank
            ldpc_cw_bank #(
                .CW_BITS (CW_BITS),
                .DIN_W   (DIN_W)
            ) u_bank (
                .clk      (clk),
                .rst_n    (rst_n),
                .shift_en (shift_en[i]),
                .d_in     (d_in),
                .set_full (set_full[i]),
                .clr_full (clr_full[i]),
                .data     (bank_data[i]),
                .full     (bank_full[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            beat_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            // The stale partial frame is simply overwritten by the next full frame.
            if (abort) begin
                beat_cnt <= '0;
            end else if (last_beat) begin
                beat_cnt <= '0;
                wr_sel   <= !wr_sel;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (take) begin
                rd_sel <= !rd_sel;
            end

            // A fresh drop must stay visible even if software clears in the same cycle.
            if (en_din && !in_rdy) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_cw_loader.sv
module tb_ldpc_cw_loader;

    logic        clk;
    logic        rst_n;
    logic        en_din;
    logic [7:0]  d_in;
    logic        abort;
    logic        in_rdy;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        frame_take;
    logic        ovf_err;
    logic        err_clr;
    logic [1:0]  beat_cnt;

    // Production-geometry instance
    logic          big_en;
    logic [7:0]    big_d;
    logic          big_rdy;
    logic          big_valid;
    logic [9215:0] big_data;
    logic          big_ovf;
    logic [10:0]   big_cnt;

    int checks   = 0;
    int failures = 0;

    ldpc_cw_loader #(.CW_BITS(32), .DIN_W(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_din      (en_din),
        .d_in        (d_in),
        .abort       (abort),
        .in_rdy      (in_rdy),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_take  (frame_take),
        .ovf_err     (ovf_err),
        .err_clr     (err_clr),
        .beat_cnt    (beat_cnt)
    );

    ldpc_cw_loader u_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_din      (big_en),
        .d_in        (big_d),
        .abort       (1'b0),
        .in_rdy      (big_rdy),
        .frame_valid (big_valid),
        .frame_data  (big_data),
        .frame_take  (1'b0),
        .ovf_err     (big_ovf),
        .err_clr     (1'b0),
        .beat_cnt    (big_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d);
        en_din = 1'b1;
        d_in   = d;
        tick();
        en_din = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int b = 0; b < 4; b++) begin
            send_beat(f[31-8*b -: 8]);
        end
    endtask

    task automatic take_frame();
        frame_take = 1'b1;
        tick();
        frame_take = 1'b0;
    endtask

    // Streaming scoreboard
    logic [31:0] exp_q[$];
    int          delivered = 0;
    int          rdy_low   = 0;

    task automatic service();
        frame_take = frame_valid;
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                check("stream_extra_frame", 64'd1, 64'd0);
            end else begin
                check("stream_frame", 64'(frame_data), 64'(exp_q.pop_front()));
            end
            delivered++;
        end
    endtask

    initial begin
        logic [31:0] fr;
        rst_n      = 1'b0;
        en_din     = 1'b0;
        d_in       = '0;
        abort      = 1'b0;
        frame_take = 1'b0;
        err_clr    = 1'b0;
        big_en     = 1'b0;
        big_d      = '0;
        tick();
        tick();

        // Reset state
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_frame_data", 64'(frame_data), 64'd0);
        check("rst_ovf_err", 64'(ovf_err), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single frame
        send_beat(8'h11);
        send_beat(8'h22);
        send_beat(8'h33);
        check("single_cnt3", 64'(beat_cnt), 64'd3);
        check("single_not_valid_yet", 64'(frame_valid), 64'd0);
        send_beat(8'h44);
        check("single_valid", 64'(frame_valid), 64'd1);
        check("single_data", 64'(frame_data), 64'h11223344);
        check("single_cnt0", 64'(beat_cnt), 64'd0);
        check("single_in_rdy", 64'(in_rdy), 64'd1);
        take_frame();
        check("single_taken", 64'(frame_valid), 64'd0);

        // Ping-pong with both banks full
        send_frame(32'hA1A2A3A4);
        send_frame(32'hB1B2B3B4);
        check("pp_in_rdy_low", 64'(in_rdy), 64'd0);
        check("pp_data_a", 64'(frame_data), 64'hA1A2A3A4);

        // Overflow while both banks full
        send_beat(8'h55);
        check("ovf_set", 64'(ovf_err), 64'd1);
        check("ovf_data_unchanged", 64'(frame_data), 64'hA1A2A3A4);
        check("ovf_cnt_unchanged", 64'(beat_cnt), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared", 64'(ovf_err), 64'd0);
        err_clr = 1'b1;
        send_beat(8'h66);
        err_clr = 1'b0;
        check("ovf_set_beats_clr", 64'(ovf_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        take_frame();
        check("pp_data_b", 64'(frame_data), 64'hB1B2B3B4);
        check("pp_rdy_after_take", 64'(in_rdy), 64'd1);
        take_frame();
        check("pp_empty", 64'(frame_valid), 64'd0);
        check("pp_rdy_empty", 64'(in_rdy), 64'd1);

        // Abort between frames
        send_beat(8'hE1);
        send_beat(8'hE2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_cnt", 64'(beat_cnt), 64'd0);
        check("abort_no_frame", 64'(frame_valid), 64'd0);
        send_frame(32'h01020304);
        check("abort_data", 64'(frame_data), 64'h01020304);
        take_frame();

        // Abort coincident with a beat
        send_beat(8'h10);
        send_beat(8'h20);
        abort = 1'b1;
        send_beat(8'h99);
        abort = 1'b0;
        check("abort_beat_cnt", 64'(beat_cnt), 64'd0);
        check("abort_beat_ovf", 64'(ovf_err), 64'd0);
        send_beat(8'hC1);
        send_beat(8'hC2);
        send_beat(8'hC3);
        check("abort_beat_not_full", 64'(frame_valid), 64'd0);
        send_beat(8'hC4);
        check("abort_beat_data", 64'(frame_data), 64'hC1C2C3C4);
        take_frame();

        // Full-rate streaming with immediate takes
        for (int f = 0; f < 100; f++) begin
            fr = $urandom;
            for (int b = 0; b < 4; b++) begin
                service();
                en_din = 1'b1;
                d_in   = fr[31-8*b -: 8];
                if (!in_rdy) rdy_low++;
                if (b == 3) exp_q.push_back(fr);
                tick();
            end
        end
        en_din = 1'b0;
        for (int c = 0; c < 20; c++) begin
            service();
            tick();
        end
        frame_take = 1'b0;
        check("stream_delivered", 64'(delivered), 64'd100);
        check("stream_rdy_low", 64'(rdy_low), 64'd0);
        check("stream_ovf", 64'(ovf_err), 64'd0);

        // Reset mid-frame
        send_beat(8'h71);
        send_beat(8'h72);
        send_beat(8'h73);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 64'(beat_cnt), 64'd0);
        check("mid_rst_valid", 64'(frame_valid), 64'd0);
        check("mid_rst_data", 64'(frame_data), 64'd0);
        check("mid_rst_rdy", 64'(in_rdy), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(32'hDEADBEEF);
        check("post_rst_valid", 64'(frame_valid), 64'd1);
        check("post_rst_data", 64'(frame_data), 64'hDEADBEEF);

        // Production geometry: 1152 beats per frame
        check("big_rst_rdy", 64'(big_rdy), 64'd1);
        for (int i = 0; i < 1152; i++) begin
            big_en = 1'b1;
            big_d  = (i == 0) ? 8'hA5 : 8'(i);
            tick();
            if (i == 1150) begin
                check("big_cnt_1151", 64'(big_cnt), 64'd1151);
                check("big_not_valid_1151", 64'(big_valid), 64'd0);
            end
        end
        big_en = 1'b0;
        check("big_valid_1152", 64'(big_valid), 64'd1);
        check("big_first_beat_msb", 64'(big_data[9215:9208]), 64'hA5);
        check("big_last_beat_lsb", 64'(big_data[7:0]), 64'h7F);
        check("big_cnt_wrap", 64'(big_cnt), 64'd0);
        check("big_ovf", 64'(big_ovf), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldpc_cw_loader.md
# ldpc_cw_loader

Parametrised input front end for the QC-LDPC decoder: deserialises a DIN_W-bit beat stream into CW_BITS-bit codewords held in two ping-pong banks. The decoder core can iterate on one frame while the next is loaded, with flow control and overflow reporting. Sits between the byte-stream source and the NMS decoder input, in place of a single-buffer loader.

## Interface
- DIN_W, 8, input beat width in bits; must divide CW_BITS.
- CW_BITS, 9216, codeword length in bits.
- BEATS (derived), CW_BITS/DIN_W, beats per frame; counter width CNT_W = $clog2(BEATS).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- en_din  in  1  beat valid.
- d_in  in  DIN_W  beat data.
- abort  in  1  discard the partial frame in the write bank.
- in_rdy  out  1  loader can accept a beat this cycle.
- frame_valid  out  1  a complete frame is available on frame_data.
- frame_data  out  CW_BITS  oldest complete frame.
- frame_take  in  1  consumer has latched frame_data; ignored unless frame_valid.
- ovf_err  out  1  sticky: a beat arrived while in_rdy was low.
- err_clr  in  1  clears ovf_err.
- beat_cnt  out  CNT_W  beats accepted into the current write bank.

## Operation
- Two banks, each holding CW_BITS data bits and a full flag. wr_sel selects the write bank, rd_sel the read bank; both reset to 0.
- in_rdy = !full[wr_sel].
- Accept condition: en_din && in_rdy. On accept, bank[wr_sel] <= {bank[wr_sel][CW_BITS-DIN_W-1:0], d_in}. The first beat of a frame ends in the MSBs.
- On accept with beat_cnt == BEATS-1:
  - full[wr_sel] set, wr_sel toggles, beat_cnt <= 0.
  - Otherwise beat_cnt increments.
- frame_valid = full[rd_sel]; frame_data = bank[rd_sel].
- frame_take && frame_valid: full[rd_sel] cleared, rd_sel toggles. The bank data is not cleared.
- en_din && !in_rdy: beat dropped, ovf_err set. Set has priority over a simultaneous err_clr.
- abort: beat_cnt <= 0. The write bank's partial contents are stale and are overwritten by the next frame. Abort wins over a simultaneous accept; that beat is dropped without setting ovf_err. Complete banks are unaffected.
- Simultaneous last-beat accept and frame_take on the other bank: both actions occur.
- Simultaneous last-beat accept and frame_take on the same bank is impossible, because in_rdy is low whenever the write bank is full.

## Timing
- Reset values: in_rdy 1 (both full flags clear), frame_valid 0, frame_data 0, ovf_err 0, beat_cnt 0, wr_sel/rd_sel 0.
- Reset may assert mid-frame; the partial frame and any full banks are lost.
- All state is registered. Outputs are functions of registers only; there is no combinational path from any input to any output.
- Latency: the last beat accepted at edge k gives frame_valid = 1 from edge k to the following take.
- frame_take at edge k: the next frame is visible, or frame_valid drops, after edge k.
- Both banks full: in_rdy is 0. A frame_take at edge k raises in_rdy after edge k, so the first new beat can be accepted at edge k+1.
- Sustained throughput: one beat per cycle, provided the consumer takes each frame within BEATS cycles of its completion.

## Structure
- Shared package ldpc_pkg holds:
  - the CW_BITS default (9216) and DIN_W default (8);
  - a function computing BEATS and CNT_W;
  - the elaboration-time check CW_BITS % DIN_W == 0.
- One sub-module, ldpc_cw_bank (shift-in register plus full flag, with set/clear inputs), instantiated twice.
- Bank-select, counter and error logic live in the top.

## Test plan
Test configuration: CW_BITS=32, DIN_W=8 unless stated.
- Single frame: beats 0x11,0x22,0x33,0x44 back-to-back -> frame_valid rises after the 4th beat, frame_data=0x11223344, beat_cnt returns to 0; frame_take -> frame_valid 0 next cycle.
- Ping-pong: two frames A=0xA1A2A3A4 and B=0xB1B2B3B4 with no take -> in_rdy=0 after B. Take A -> frame_data=B. Take B -> frame_valid=0, in_rdy stays 1.
- Overflow: with both banks full, drive a beat 0x55 -> ovf_err=1 and the banks are unchanged. err_clr -> ovf_err=0. err_clr together with another dropped beat -> ovf_err stays 1.
- Abort: send 2 beats, then abort, then 0x01,0x02,0x03,0x04 -> frame_data=0x01020304. Abort coincident with a beat -> that beat is discarded and ovf_err=0.
- Streaming at full rate, take asserted each frame_valid cycle, 100 random frames -> all frames delivered in order, in_rdy never low, ovf_err=0.
- Reset mid-frame after 3 beats, then a fresh 4-beat frame 0xDEADBEEF -> outputs at reset values during reset, frame_data=0xDEADBEEF.
- Default parameters (9216/8): 1152 beats -> frame_valid exactly after beat 1152, first beat in bits [9215:9208].
